stream_pkt_fifo: RTL and testbench
==================================

STREAM_PKT_FIFO -- requirements
Module: stream_pkt_fifo

Interface
- REQ-001 Parameters (name, default, meaning), one per line:
  - T_DATA_WIDTH, 8, beat data width.
  - T_ID___WIDTH, 3, source-id width carried with each beat.
  - DEPTH, 4, storage depth in beats; power of two, at least 2.
  - PACKET_MODE, 1, 1 = release beats only once a complete packet is stored; 0 = plain first-word-fall-through FIFO.
- REQ-002 Ports (name, direction, width, meaning), one per line:
  - clk, in, 1, single clock; all state changes on its rising edge.
  - rst_n, in, 1, reset; asynchronous, active-low.
  - s_data_i, in, T_DATA_WIDTH, input beat data from the crossbar master port.
  - s_id_i, in, T_ID___WIDTH, source id of the beat.
  - s_last_i, in, 1, final beat of a packet.
  - s_valid_i, in, 1, input beat valid.
  - s_ready_o, out, 1, FIFO accepts a beat.
  - m_data_o, out, T_DATA_WIDTH, head beat data.
  - m_id_o, out, T_ID___WIDTH, head beat id.
  - m_last_o, out, 1, head beat is last.
  - m_valid_o, out, 1, head beat valid.
  - m_ready_i, in, 1, downstream accepts the head beat.
  - count_o, out, $clog2(DEPTH)+1, number of stored beats.
  - pkt_count_o, out, $clog2(DEPTH)+1, number of complete packets stored (last beat written, not yet read).

Function
- REQ-003 Write occurs on a rising edge when s_valid_i and s_ready_o are both 1; the write stores {s_data_i, s_id_i, s_last_i} at the write pointer.
- REQ-004 Read occurs on a rising edge when m_valid_o and m_ready_i are both 1; the read advances the read pointer.
- REQ-005 s_ready_o = (count_o != DEPTH), decoded combinationally from registered state.
- REQ-006 While full, no write is accepted, even if a read occurs on the same edge.
- REQ-007 Write and read pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; the storage index is the low $clog2(DEPTH) bits.
- REQ-008 Empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
- REQ-009 count_o update per edge:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous write and read, or on neither.
- REQ-010 m_data_o, m_id_o and m_last_o always show the entry at the read pointer (first-word fall-through, no output register).
- REQ-011 PACKET_MODE=0: m_valid_o = !empty; a beat written at edge N is presented with m_valid_o=1 immediately after edge N.
- REQ-012 PACKET_MODE=1: m_valid_o = !empty && (pkt_count_o != 0 || full).
  - The full term is overflow release: a packet longer than DEPTH drains rather than deadlocking.
- REQ-013 pkt_count_o update per edge:
  - +1 on a write with s_last_i=1.
  - -1 on a read with m_last_o=1.
  - Unchanged when both occur on the same edge.
- REQ-014 Reading non-last beats never changes pkt_count_o; pkt_count_o never exceeds count_o.
- REQ-015 Input that is valid while s_ready_o=0 is ignored; no state change.
- REQ-016 After m_valid_o is asserted, it deasserts only by a read or by reset.
- REQ-017 Beat order and the {data, id, last} association are preserved exactly.

Reset
- REQ-018 rst_n low asynchronously clears both pointers, count_o, pkt_count_o and all storage entries to 0, regardless of clk.
- REQ-019 While rst_n is low, outputs are: s_ready_o=1, m_valid_o=0, m_data_o=0, m_id_o=0, m_last_o=0, count_o=0, pkt_count_o=0.
- REQ-020 A beat presented on the first rising edge after rst_n rises is accepted normally.
- REQ-021 Reset asserted mid-packet discards all stored beats, including partial packets.

Verification (DEPTH=4 unless noted)
- REQ-022 Reset: hold rst_n=0 with s_valid_i=1 -> s_ready_o=1, m_valid_o=0, count_o=0, m_data_o=0.
- REQ-023 PACKET_MODE=1, m_ready_i=1: write 0x11, 0x22, 0x33(last), all with id 3 ->
  - m_valid_o stays 0 until the edge that writes 0x33.
  - Then, over 3 consecutive cycles, m_data_o=0x11, 0x22, 0x33 with m_id_o=3 and m_last_o=1 on 0x33 only.
  - Afterwards count_o=0 and pkt_count_o=0.
- REQ-024 PACKET_MODE=1, m_ready_i=0: write 4 beats with no last ->
  - count_o=4, s_ready_o=0, pkt_count_o=0, m_valid_o=1 (overflow release).
  - A fifth beat is ignored.
- REQ-025 count_o=2 with one complete packet stored; write and read on the same edge -> count_o stays 2 and the read beat is the oldest entry.
- REQ-026 PACKET_MODE=0: write a single beat 0xA5 with id 2 and no last -> m_valid_o=1 the following cycle with m_data_o=0xA5 and m_id_o=2.
- REQ-027 count_o=3: drop rst_n between clock edges -> m_valid_o=0 and count_o=0 immediately; a packet written after release is output intact.

Source files
------------

// File: rtl/stream_pkt_fifo.sv
// Stream FIFO with optional packet-mode release: beats are held until a
// complete packet (or a full FIFO) is present, then drained first-word-fall-through.
module stream_pkt_fifo #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_ID___WIDTH = 3,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PACKET_MODE  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [T_DATA_WIDTH-1:0]   s_data_i,
  input  logic [T_ID___WIDTH-1:0]   s_id_i,
  input  logic                      s_last_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  output logic [T_DATA_WIDTH-1:0]   m_data_o,
  output logic [T_ID___WIDTH-1:0]   m_id_o,
  output logic                      m_last_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [$clog2(DEPTH):0]    pkt_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [T_DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [T_ID___WIDTH-1:0] mem_id   [DEPTH];
  logic [DEPTH-1:0]        mem_last;

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;

  logic empty_c;
  logic full_c;
  logic wr_en_c;
  logic rd_en_c;
  logic wr_last_c;
  logic rd_last_c;

  // Pointer-based occupancy flags; the extra MSB distinguishes full from empty.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign s_ready_o = (count_o != CW'(DEPTH));

  // Full term lets an over-long packet drain instead of deadlocking.
  assign m_valid_o = !empty_c &&
                     ((PACKET_MODE == 0) || (pkt_count_o != '0) || full_c);

  assign m_data_o = mem_data[rd_ptr[AW-1:0]];
  assign m_id_o   = mem_id[rd_ptr[AW-1:0]];
  assign m_last_o = mem_last[rd_ptr[AW-1:0]];

  assign wr_en_c   = s_valid_i && s_ready_o;
  assign rd_en_c   = m_valid_o && m_ready_i;
  assign wr_last_c = wr_en_c && s_last_i;
  assign rd_last_c = rd_en_c && m_last_o;

  // Beat storage; cleared on reset so the head shows zeros while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_id[i]   <= '0;
      end
      mem_last <= '0;
    end else if (wr_en_c) begin
      mem_data[wr_ptr[AW-1:0]] <= s_data_i;
      mem_id[wr_ptr[AW-1:0]]   <= s_id_i;
      mem_last[wr_ptr[AW-1:0]] <= s_last_i;
    end
  end

  // Read and write pointers, wrapping modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + CW'(1);
      if (rd_en_c) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Stored-beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else begin
      case ({wr_en_c, rd_en_c})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  // Complete-packet counter: last beat written in, last beat read out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_o <= '0;
    end else begin
      case ({wr_last_c, rd_last_c})
        2'b10:   pkt_count_o <= pkt_count_o + CW'(1);
        2'b01:   pkt_count_o <= pkt_count_o - CW'(1);
        default: pkt_count_o <= pkt_count_o;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// Bench for stream_pkt_fifo: a packet-mode and a plain-FIFO instance share the
// same stimulus; each has its own queue-based reference model and scoreboard.
module tb_stream_pkt_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned IW    = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [DW-1:0] s_data;
  logic [IW-1:0] s_id;
  logic s_last;
  logic s_valid;
  logic m_ready;

  logic          s_ready [2];
  logic [DW-1:0] m_data  [2];
  logic [IW-1:0] m_id    [2];
  logic          m_last  [2];
  logic          m_valid [2];
  logic [CW-1:0] count   [2];
  logic [CW-1:0] pkt     [2];

  // Index 0: packet mode, index 1: plain FIFO.
  beat_t sb [2][$];

  int n_chk  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  stream_pkt_fifo #(.T_DATA_WIDTH(DW), .T_ID___WIDTH(IW), .DEPTH(DEPTH), .PACKET_MODE(1)) u_pkt (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data), .s_id_i(s_id), .s_last_i(s_last), .s_valid_i(s_valid),
    .s_ready_o(s_ready[0]),
    .m_data_o(m_data[0]), .m_id_o(m_id[0]), .m_last_o(m_last[0]), .m_valid_o(m_valid[0]),
    .m_ready_i(m_ready),
    .count_o(count[0]), .pkt_count_o(pkt[0])
  );

  stream_pkt_fifo #(.T_DATA_WIDTH(DW), .T_ID___WIDTH(IW), .DEPTH(DEPTH), .PACKET_MODE(0)) u_fwft (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data), .s_id_i(s_id), .s_last_i(s_last), .s_valid_i(s_valid),
    .s_ready_o(s_ready[1]),
    .m_data_o(m_data[1]), .m_id_o(m_id[1]), .m_last_o(m_last[1]), .m_valid_o(m_valid[1]),
    .m_ready_i(m_ready),
    .count_o(count[1]), .pkt_count_o(pkt[1])
  );

  function automatic void chk(input string name, input int k,
                              input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp);
    end
  endfunction

  // Scoreboard monitor: compare against the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    int   n;
    int   np;
    logic ev;
    logic er;
    beat_t b;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          chk("rst_s_ready", k, 32'(s_ready[k]), 32'(1));
          chk("rst_m_valid", k, 32'(m_valid[k]), 32'(0));
          chk("rst_m_data",  k, 32'(m_data[k]),  32'(0));
          chk("rst_m_id",    k, 32'(m_id[k]),    32'(0));
          chk("rst_m_last",  k, 32'(m_last[k]),  32'(0));
          chk("rst_count",   k, 32'(count[k]),   32'(0));
          chk("rst_pkt",     k, 32'(pkt[k]),     32'(0));
        end else begin
          n  = sb[k].size();
          np = 0;
          for (int i = 0; i < n; i++) if (sb[k][i].last) np++;
          er = (n < int'(DEPTH));
          ev = (n > 0) && ((k == 1) || (np > 0) || (n == int'(DEPTH)));
          chk("count",   k, 32'(count[k]),   32'(n));
          chk("pkt",     k, 32'(pkt[k]),     32'(np));
          chk("s_ready", k, 32'(s_ready[k]), 32'(er));
          chk("m_valid", k, 32'(m_valid[k]), 32'(ev));
          if (n > 0) begin
            chk("head_data", k, 32'(m_data[k]), 32'(sb[k][0].data));
            chk("head_id",   k, 32'(m_id[k]),   32'(sb[k][0].id));
            chk("head_last", k, 32'(m_last[k]), 32'(sb[k][0].last));
          end
          if (m_ready && ev) void'(sb[k].pop_front());
          if (s_valid && er) begin
            b.data = s_data;
            b.id   = s_id;
            b.last = s_last;
            sb[k].push_back(b);
          end
        end
      end
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [IW-1:0] id,
                     input logic l, input logic mr);
    @(posedge clk);
    #1;
    s_valid = v;
    s_data  = d;
    s_id    = id;
    s_last  = l;
    m_ready = mr;
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 3'd0, 1'b0, mr);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    s_id    = 3'd1;
    s_last  = 1'b1;
    m_ready = 1'b1;
    mon_en  = 1'b1;

    // Reset held with valid input present.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("r22_s_ready", k, 32'(s_ready[k]), 32'(1));
      chk("r22_m_valid", k, 32'(m_valid[k]), 32'(0));
      chk("r22_count",   k, 32'(count[k]),   32'(0));
      chk("r22_m_data",  k, 32'(m_data[k]),  32'(0));
    end
    #1 rst_n = 1'b1;
    // 0x5A is accepted on the first edge after release.
    @(posedge clk);
    #1;
    chk("r20_count", 0, 32'(count[0]), 32'(1));
    s_valid = 1'b0;
    idle(3, 1'b1);

    // Three-beat packet: packet mode withholds until the last beat lands.
    cyc(1'b1, 8'h11, 3'd3, 1'b0, 1'b1);
    cyc(1'b1, 8'h22, 3'd3, 1'b0, 1'b1);
    cyc(1'b1, 8'h33, 3'd3, 1'b1, 1'b1);
    chk("r23_hold", 0, 32'(m_valid[0]), 32'(0));
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("r23_rel_valid", 0, 32'(m_valid[0]), 32'(1));
    chk("r23_rel_data",  0, 32'(m_data[0]),  32'(8'h11));
    idle(5, 1'b1);
    chk("r23_count", 0, 32'(count[0]), 32'(0));
    chk("r23_pkt",   0, 32'(pkt[0]),   32'(0));

    // Fill without a last beat: overflow release, fifth beat ignored.
    cyc(1'b1, 8'hE1, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 8'hE2, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 8'hE3, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 8'hE4, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 3'd5, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("r24_count",   k, 32'(count[k]),   32'(4));
      chk("r24_s_ready", k, 32'(s_ready[k]), 32'(0));
      chk("r24_pkt",     k, 32'(pkt[k]),     32'(0));
      chk("r24_m_valid", k, 32'(m_valid[k]), 32'(1));
      chk("r24_head",    k, 32'(m_data[k]),  32'(8'hE1));
    end
    idle(2, 1'b1);
    cyc(1'b1, 8'h5F, 3'd4, 1'b1, 1'b1);
    idle(8, 1'b1);

    // Simultaneous write and read with one complete packet stored.
    cyc(1'b1, 8'hA1, 3'd1, 1'b1, 1'b0);
    cyc(1'b1, 8'hA2, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 8'hA3, 3'd1, 1'b0, 1'b1);
    chk("r25_pre_count", 0, 32'(count[0]), 32'(2));
    chk("r25_pre_pkt",   0, 32'(pkt[0]),   32'(1));
    chk("r25_pre_head",  0, 32'(m_data[0]), 32'(8'hA1));
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("r25_count", k, 32'(count[k]),  32'(2));
      chk("r25_head",  k, 32'(m_data[k]), 32'(8'hA2));
    end
    cyc(1'b1, 8'hA4, 3'd1, 1'b1, 1'b1);
    idle(6, 1'b1);

    // Plain FIFO presents a single non-last beat right after the write.
    cyc(1'b1, 8'hA5, 3'd2, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("r26_valid", 1, 32'(m_valid[1]), 32'(1));
    chk("r26_data",  1, 32'(m_data[1]),  32'(8'hA5));
    chk("r26_id",    1, 32'(m_id[1]),    32'(2));
    chk("r26_pkt_hold", 0, 32'(m_valid[0]), 32'(0));
    cyc(1'b1, 8'hA6, 3'd2, 1'b1, 1'b1);
    idle(6, 1'b1);

    // Asynchronous reset mid-packet, then a clean packet afterwards.
    cyc(1'b1, 8'hB1, 3'd6, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 3'd6, 1'b0, 1'b0);
    cyc(1'b1, 8'hB3, 3'd6, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("r27_pre_count", 0, 32'(count[0]), 32'(3));
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("r27_m_valid", k, 32'(m_valid[k]), 32'(0));
      chk("r27_count",   k, 32'(count[k]),   32'(0));
      chk("r27_pkt",     k, 32'(pkt[k]),     32'(0));
    end
    sb[0].delete();
    sb[1].delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1'b1, 8'hC1, 3'd7, 1'b0, 1'b1);
    cyc(1'b1, 8'hC2, 3'd7, 1'b0, 1'b1);
    cyc(1'b1, 8'hC3, 3'd7, 1'b1, 1'b1);
    idle(6, 1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 60, 8'($urandom), 3'($urandom),
          $urandom_range(0, 2) == 0, $urandom_range(0, 99) < 70);
    end

    // Terminate any open packet, then drain.
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'hF0 + i), 3'd0, 1'b1, 1'b1);
    idle(16, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("end_count", k, 32'(count[k]), 32'(0));
      chk("end_pkt",   k, 32'(pkt[k]),   32'(0));
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
